// File: rtl/smpl_iter_pkg.sv
// Shared types and decode helpers for the sample iterator.
package smpl_iter_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } smpl_state_e;

    // One-hot sample rate to log2 samples-per-pixel-width; lowest set bit wins.
    function automatic logic [1:0] ss_w_lg2(input logic [3:0] ss);
        if (ss[0])      return 2'd3;
        else if (ss[1]) return 2'd2;
        else if (ss[2]) return 2'd1;
        else            return 2'd0;
    endfunction

endpackage

// File: rtl/smpl_iter_step.sv
// Next raster position (x-fastest) and last-sample detect for the sample iterator.
module smpl_iter_step #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] i_x,
    input  logic signed [SIGFIG-1:0] i_y,
    input  logic signed [SIGFIG-1:0] i_llx,
    input  logic signed [SIGFIG-1:0] i_urx,
    input  logic signed [SIGFIG-1:0] i_ury,
    input  logic signed [SIGFIG-1:0] i_step,
    output logic signed [SIGFIG-1:0] o_nx,
    output logic signed [SIGFIG-1:0] o_ny,
    output logic                     o_last
);

    always_comb begin
        o_nx = i_x;
        o_ny = i_y;
        if (i_x < i_urx) begin
            o_nx = i_x + i_step;
        end else begin
            o_nx = i_llx;
            o_ny = i_y + i_step;
        end
    end

    assign o_last = (i_x == i_urx) && (i_y == i_ury);

endmodule

// File: rtl/smpl_iter_ctl.sv
// Walks a triangle's bounding box on the sample grid, one sample per cycle.
// Optional SMPL_ITER_STATS_EN adds saturating triangle/sample counters.
module smpl_iter_ctl
    import smpl_iter_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                         validTri_R13H,
    input  logic        [3:0]                            subSample_RnnnnU,
    output logic                                         halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                         validSamp_R14H
`ifdef SMPL_ITER_STATS_EN
    ,
    output logic        [31:0]                           tri_cnt_RnnU,
    output logic        [31:0]                           samp_cnt_RnnU
`endif
);

    smpl_state_e r_state, w_nstate;

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
    logic        [COLORS-1:0][SIGFIG-1:0]          r_color;
    logic signed [SIGFIG-1:0] r_x, r_y, r_llx, r_urx, r_ury, r_step;
    logic signed [SIGFIG-1:0] w_nx, w_ny, w_step_in;
    logic w_last_raw, w_last, w_accept, w_load, w_adv, w_halt;

    assign w_step_in = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(ss_w_lg2(subSample_RnnnnU)));

    smpl_iter_step #(.SIGFIG(SIGFIG)) u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_llx  (r_llx),
        .i_urx  (r_urx),
        .i_ury  (r_ury),
        .i_step (r_step),
        .o_nx   (w_nx),
        .o_ny   (w_ny),
        .o_last (w_last_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_WAIT;
        else     r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        w_load   = 1'b0;
        w_adv    = 1'b0;
        w_last   = (r_state == ST_TEST) && w_last_raw;
        w_halt   = (r_state == ST_WAIT) || w_last;
        w_accept = validTri_R13H && w_halt;
        case (r_state)
            ST_WAIT: begin
                if (w_accept) begin
                    w_load   = 1'b1;
                    w_nstate = ST_TEST;
                end
            end
            ST_TEST: begin
                // On the last sample a waiting triangle loads with no bubble.
                if (w_last) begin
                    if (w_accept) w_load   = 1'b1;
                    else          w_nstate = ST_WAIT;
                end else begin
                    w_adv = 1'b1;
                end
            end
            default: w_nstate = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tri   <= '0;
            r_color <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_llx   <= '0;
            r_urx   <= '0;
            r_ury   <= '0;
            r_step  <= '0;
        end else if (w_load) begin
            r_tri   <= tri_R13S;
            r_color <= color_R13U;
            r_x     <= $signed(box_R13S[0][0]);
            r_y     <= $signed(box_R13S[0][1]);
            r_llx   <= $signed(box_R13S[0][0]);
            r_urx   <= $signed(box_R13S[1][0]);
            r_ury   <= $signed(box_R13S[1][1]);
            r_step  <= w_step_in;
        end else if (w_adv) begin
            r_x     <= w_nx;
            r_y     <= w_ny;
        end
    end

    assign halt_RnnnnL    = w_halt;
    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = {r_y, r_x};
    assign validSamp_R14H = (r_state == ST_TEST);

`ifdef SMPL_ITER_STATS_EN
    logic [31:0] r_tri_cnt, r_samp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tri_cnt  <= '0;
            r_samp_cnt <= '0;
        end else begin
            if (w_load && (r_tri_cnt != '1))
                r_tri_cnt <= r_tri_cnt + 32'd1;
            if (validSamp_R14H && (r_samp_cnt != '1))
                r_samp_cnt <= r_samp_cnt + 32'd1;
        end
    end

    assign tri_cnt_RnnU  = r_tri_cnt;
    assign samp_cnt_RnnU = r_samp_cnt;
`endif

endmodule

// File: tb/tb_smpl_iter_ctl.sv
// Directed bench for smpl_iter_ctl: raster order, back-to-back, stall and reset abort.
module tb_smpl_iter_ctl;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;

    logic clk = 1'b0;
    logic rst;
    tri_t tri_in, tri_out;
    col_t col_in, col_out;
    logic [1:0][1:0][SIGFIG-1:0] box_in;
    logic        vld_in;
    logic [3:0]  ss;
    logic        halt;
    logic [1:0][SIGFIG-1:0] samp;
    logic        vld_out;
`ifdef SMPL_ITER_STATS_EN
    logic [31:0] tri_cnt, samp_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    smpl_iter_ctl #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (col_in),
        .box_R13S         (box_in),
        .validTri_R13H    (vld_in),
        .subSample_RnnnnU (ss),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (col_out),
        .sample_R14S      (samp),
        .validSamp_R14H   (vld_out)
`ifdef SMPL_ITER_STATS_EN
        ,
        .tri_cnt_RnnU     (tri_cnt),
        .samp_cnt_RnnU    (samp_cnt)
`endif
    );

    function automatic tri_t tri_pat(input int tag);
        tri_t r;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                r[v][a] = SIGFIG'(tag * 100 + v * 10 + a);
        return r;
    endfunction

    function automatic col_t col_pat(input int tag);
        col_t r;
        for (int c = 0; c < COLORS; c++)
            r[c] = SIGFIG'(tag * 1000 + c);
        return r;
    endfunction

    task automatic set_tri(input int tag, input int llx, input int lly, input int urx, input int ury);
        tri_in       = tri_pat(tag);
        col_in       = col_pat(tag);
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
    endtask

    task automatic test_reset();
        rst = 1'b1; vld_in = 1'b0; ss = 4'b1000;
        set_tri(0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL reset_ctl: got vld=%b halt=%b want vld=0 halt=1", vld_out, halt);
        end
        n_cmp++;
        if (samp !== '0 || tri_out !== '0 || col_out !== '0) begin
            n_bad++; $display("FAIL reset_data: got samp=%h tri=%h col=%h want all 0", samp, tri_out, col_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL reset_idle: got vld=%b halt=%b want vld=0 halt=1", vld_out, halt);
        end
    endtask

    task automatic test_ss4();
        int ex[6] = '{0, 512, 1024, 0, 512, 1024};
        int ey[6] = '{0, 0, 0, 512, 512, 512};
        @(negedge clk);
        set_tri(1, 0, 0, 1024, 512); ss = 4'b0100; vld_in = 1'b1;
        @(posedge clk); #1 vld_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(ex[k]) || samp[1] !== SIGFIG'(ey[k])) begin
                n_bad++; $display("FAIL ss4_samp%0d: got vld=%b (%0d,%0d) want vld=1 (%0d,%0d)",
                                  k, vld_out, $signed(samp[0]), $signed(samp[1]), ex[k], ey[k]);
            end
            n_cmp++;
            if (halt !== (k == 5)) begin
                n_bad++; $display("FAIL ss4_halt%0d: got %b want %b", k, halt, (k == 5));
            end
        end
        n_cmp++;
        if (tri_out !== tri_pat(1) || col_out !== col_pat(1)) begin
            n_bad++; $display("FAIL ss4_tri: got tri=%h col=%h want tri=%h col=%h",
                              tri_out, col_out, tri_pat(1), col_pat(1));
        end
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL ss4_end: got vld=%b halt=%b want vld=0 halt=1", vld_out, halt);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_tri(2, 2048, 2048, 2048, 2048); ss = 4'b1000; vld_in = 1'b1;
        @(posedge clk); #1 vld_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(2048) || samp[1] !== SIGFIG'(2048) || halt !== 1'b1) begin
            n_bad++; $display("FAIL single_samp: got vld=%b halt=%b (%0d,%0d) want vld=1 halt=1 (2048,2048)",
                              vld_out, halt, $signed(samp[0]), $signed(samp[1]));
        end
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL single_end: got vld=%b halt=%b want vld=0 halt=1", vld_out, halt);
        end
    endtask

    task automatic test_back_to_back();
        int ex[4]  = '{0, 1024, 4096, 4096};
        int ey[4]  = '{0, 0, 4096, 5120};
        int tag[4] = '{3, 3, 4, 4};
        @(negedge clk);
        set_tri(3, 0, 0, 1024, 0); ss = 4'b1000; vld_in = 1'b1;
        @(posedge clk); #1 set_tri(4, 4096, 4096, 4096, 5120);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(ex[k]) || samp[1] !== SIGFIG'(ey[k]) ||
                tri_out !== tri_pat(tag[k])) begin
                n_bad++; $display("FAIL b2b_samp%0d: got vld=%b (%0d,%0d) tri=%h want vld=1 (%0d,%0d) tri=%h",
                                  k, vld_out, $signed(samp[0]), $signed(samp[1]), tri_out,
                                  ex[k], ey[k], tri_pat(tag[k]));
            end
            n_cmp++;
            if (halt !== (k == 1 || k == 3)) begin
                n_bad++; $display("FAIL b2b_halt%0d: got %b want %b", k, halt, (k == 1 || k == 3));
            end
            if (k == 2) vld_in = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL b2b_end: got vld=%b halt=%b want vld=0 halt=1", vld_out, halt);
        end
    endtask

    task automatic test_no_capture();
        int ex[3] = '{0, 1024, 2048};
        @(negedge clk);
        set_tri(5, 0, 0, 2048, 0); ss = 4'b1000; vld_in = 1'b1;
        @(posedge clk); #1 set_tri(6, 8192, 8192, 9216, 9216);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(ex[k]) || samp[1] !== '0 ||
                tri_out !== tri_pat(5) || col_out !== col_pat(5)) begin
                n_bad++; $display("FAIL nocap_samp%0d: got vld=%b (%0d,%0d) tri=%h want vld=1 (%0d,0) tri=%h",
                                  k, vld_out, $signed(samp[0]), $signed(samp[1]), tri_out, ex[k], tri_pat(5));
            end
            n_cmp++;
            if (halt !== (k == 2)) begin
                n_bad++; $display("FAIL nocap_halt%0d: got %b want %b", k, halt, (k == 2));
            end
            if (k == 1) vld_in = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0 || tri_out !== tri_pat(5)) begin
            n_bad++; $display("FAIL nocap_end: got vld=%b tri=%h want vld=0 tri=%h", vld_out, tri_out, tri_pat(5));
        end
    endtask

    task automatic test_reset_mid();
        int ex[3] = '{0, 1024, 2048};
        @(negedge clk);
        set_tri(7, 0, 0, 3072, 3072); ss = 4'b1000; vld_in = 1'b1;
        @(posedge clk); #1 vld_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(ex[k]) || samp[1] !== '0) begin
                n_bad++; $display("FAIL rmid_samp%0d: got vld=%b (%0d,%0d) want vld=1 (%0d,0)",
                                  k, vld_out, $signed(samp[0]), $signed(samp[1]), ex[k]);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1 || samp !== '0) begin
            n_bad++; $display("FAIL rmid_abort: got vld=%b halt=%b samp=%h want vld=0 halt=1 samp=0",
                              vld_out, halt, samp);
        end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL rmid_idle: got vld=%b halt=%b want vld=0 halt=1", vld_out, halt);
        end
        set_tri(8, 1024, 1024, 2048, 1024); vld_in = 1'b1;
        @(posedge clk); #1 vld_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(1024) || samp[1] !== SIGFIG'(1024) || tri_out !== tri_pat(8)) begin
            n_bad++; $display("FAIL rmid_next0: got vld=%b (%0d,%0d) want vld=1 (1024,1024)",
                              vld_out, $signed(samp[0]), $signed(samp[1]));
        end
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b1 || samp[0] !== SIGFIG'(2048) || samp[1] !== SIGFIG'(1024) || halt !== 1'b1) begin
            n_bad++; $display("FAIL rmid_next1: got vld=%b halt=%b (%0d,%0d) want vld=1 halt=1 (2048,1024)",
                              vld_out, halt, $signed(samp[0]), $signed(samp[1]));
        end
        @(negedge clk);
        n_cmp++;
        if (vld_out !== 1'b0) begin
            n_bad++; $display("FAIL rmid_end: got vld=%b want 0", vld_out);
        end
    endtask

`ifdef SMPL_ITER_STATS_EN
    task automatic test_stats();
        n_cmp++;
        if (tri_cnt !== 32'd2 || samp_cnt !== 32'd7) begin
            n_bad++; $display("FAIL stats: got tri=%0d samp=%0d want tri=2 samp=7", tri_cnt, samp_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ss4();
        test_single();
`ifdef SMPL_ITER_STATS_EN
        test_stats();
`endif
        test_back_to_back();
        test_no_capture();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/smpl_iter_ctl.md
SMPL_ITER_CTL -- requirements
Module: smpl_iter_ctl

Interface
- REQ-001 Parameter SIGFIG, default 24: bits in every position, color and screen word.
- REQ-002 Parameter RADIX, default 10: fraction bits; one pixel = 1<<RADIX.
- REQ-003 Parameter VERTS, default 3: triangle vertices.
- REQ-004 Parameter AXIS, default 3: axes per vertex (x,y,z).
- REQ-005 Parameter COLORS, default 3: color channels.
- REQ-006 Port clk, in, 1: the single clock; all state changes on posedge.
- REQ-007 Port rst, in, 1: asynchronous, active-high reset.
- REQ-008 Port tri_R13S, in, [VERTS][AXIS]xSIGFIG signed: triangle from bbox stage.
- REQ-009 Port color_R13U, in, [COLORS]xSIGFIG unsigned: triangle color.
- REQ-010 Port box_R13S, in, [2][2]xSIGFIG signed: [0]=LL corner, [1]=UR corner (x,y), sample-grid aligned.
- REQ-011 Port validTri_R13H, in, 1: triangle and box valid.
- REQ-012 Port subSample_RnnnnU, in, 4: one-hot sample rate; bit0->ss_w_lg2=3, bit1->2, bit2->1, bit3->0.
- REQ-013 Port halt_RnnnnL, out, 1: active-low stall to upstream; 1 = input accepted this cycle.
- REQ-014 Port tri_R14S, out, same shape as tri_R13S: triangle for current sample.
- REQ-015 Port color_R14U, out, same shape as color_R13U.
- REQ-016 Port sample_R14S, out, [2]xSIGFIG signed: sample (x,y).
- REQ-017 Port validSamp_R14H, out, 1: sample_R14S valid this cycle.

Function
- REQ-018 Two-state FSM: WAIT (idle, accepting) and TEST (iterating).
- REQ-019 step = 1<<(RADIX-ss_w_lg2); non-one-hot subSample SHALL decode by lowest set bit, all-zero decodes ss_w_lg2=0.
- REQ-020 halt_RnnnnL = 1 in WAIT, and in TEST only on the cycle the last sample is presented; else 0 (combinational from state).
- REQ-021 Accept = validTri_R13H && halt_RnnnnL; on accept, tri/color SHALL be captured and sample_R14S loaded with LL corner; FSM to TEST; validSamp_R14H=1 next cycle (latency 1).
- REQ-022 In TEST, each cycle: if x<URx then x+=step; else x=LLx, y+=step; one sample per cycle, no bubbles, raster order x-fastest.
- REQ-023 Last sample = (x==URx && y==URy); on it, if accept occurs the next triangle SHALL load with zero bubble, else FSM to WAIT and validSamp_R14H=0 next cycle.
- REQ-024 Single-sample box (LL==UR) SHALL emit exactly one sample.
- REQ-025 Sample count per triangle SHALL equal ((URx-LLx)/step+1)*((URy-LLy)/step+1).
- REQ-026 subSample_RnnnnU changes only in WAIT; behaviour for changes in TEST is undefined.
- REQ-027 Coordinate adds SHALL be SIGFIG-wide signed; box never exceeds screen so no overflow handling.

Reset
- REQ-028 On rst: FSM=WAIT, validSamp_R14H=0, sample_R14S/tri_R14S/color_R14U=0; halt_RnnnnL=1 immediately.
- REQ-029 Reset mid-TEST SHALL abort the triangle; no further samples from it.

Configuration
- REQ-030 Macro SMPL_ITER_STATS_EN defined: adds outputs tri_cnt_RnnU (32, triangles accepted) and samp_cnt_RnnU (32, samples emitted), saturating at all-ones, cleared by rst.
- REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
- REQ-032 Package smpl_iter_pkg SHALL hold the FSM state enum and the subSample->ss_w_lg2 decode function.
- REQ-033 Sub-module smpl_iter_step SHALL compute next (x,y) and the last-sample flag combinationally.

Verification
- REQ-034 RADIX=10, subSample=4'b0100, box (0,0)-(1024,512) -> 6 samples (0,0),(512,0),(1024,0),(0,512),(512,512),(1024,512), consecutive cycles.
- REQ-035 subSample=4'b1000, box (2048,2048)-(2048,2048) -> exactly one sample (2048,2048); FSM back to WAIT.
- REQ-036 Two triangles back-to-back with validTri held high -> second triangle's first sample the cycle after the first's last; halt_RnnnnL=1 only on last-sample cycles.
- REQ-037 rst asserted at 3rd sample of a 16-sample box -> validSamp_R14H=0 same cycle onward, halt_RnnnnL=1, next triangle starts at its LL corner.
- REQ-038 validTri_R13H=1 while in TEST (not last) -> halt_RnnnnL=0, input not captured, tri_R14S unchanged.
- REQ-039 With SMPL_ITER_STATS_EN, after REQ-034 and REQ-035 -> tri_cnt_RnnU=2, samp_cnt_RnnU=7.
